// File: rtl/wb_bus_arb.sv
// Single-master Wishbone fabric: decodes a slave index from the address, runs one
// slave access at a time, and turns unmapped slots or hung slaves into a bus error.
module wb_bus_arb #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int AW      = 22,
    parameter int SEL_LSB = 18,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     m_addr,
    input  logic [DW-1:0]     m_wdata,
    input  logic [DW/8-1:0]   m_wmsk,
    input  logic              m_we,
    input  logic              m_cyc,
    output logic [DW-1:0]     m_rdata,
    output logic              m_ack,
    output logic              m_err,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wmsk,
    output logic              s_we,
    output logic [N-1:0]      s_cyc,
    input  logic [N-1:0]      s_ack,
    input  logic [N*DW-1:0]   s_rdata
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, DECODE, BUSY, RESP, ERR, GAP} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW/8-1:0]     wmsk_q, wmsk_d;
    logic                we_q, we_d;
    logic [N-1:0]        cyc_q, cyc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic [SEL_W-1:0]    idx;
    logic                mapped;
    logic                expired;
    logic                sel_ack;
    logic [DW-1:0]       sel_rdata;

    assign idx     = addr_q[SEL_LSB +: SEL_W];
    assign mapped  = int'(idx) < N;
    assign expired = (TIMEOUT != 0) && (cnt_q == '0);

    // The registered one-hot s_cyc doubles as the response mux select, so acks
    // and data from any other slave are masked off for free.
    always_comb begin
        sel_ack   = |(s_ack & cyc_q);
        sel_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (cyc_q[i]) sel_rdata |= s_rdata[i*DW +: DW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m_cyc) state_d = DECODE;
            DECODE:  state_d = mapped ? BUSY : ERR;
            BUSY: begin
                if (sel_ack)      state_d = RESP;
                else if (expired) state_d = ERR;
            end
            RESP:    state_d = GAP;
            ERR:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmsk_d  = wmsk_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (m_cyc) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wmsk_d  = m_wmsk;
                    we_d    = m_we;
                end
            end
            DECODE: begin
                if (mapped) begin
                    for (int i = 0; i < N; i++) cyc_d[i] = (int'(idx) == i);
                    cnt_d = CNT_W'(TIMEOUT);
                end else begin
                    rdata_d = '1;
                end
            end
            BUSY: begin
                // Ack wins over expiry when both land in the same cycle.
                if (sel_ack) begin
                    rdata_d = sel_rdata;
                    cyc_d   = '0;
                end else if (expired) begin
                    rdata_d = '1;
                    cyc_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wmsk_q  <= '0;
            we_q    <= 1'b0;
            cyc_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmsk_q  <= wmsk_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign m_ack   = (state_q == RESP);
    assign m_err   = (state_q == ERR);
    assign m_rdata = rdata_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_wmsk  = wmsk_q;
    assign s_we    = we_q;
    assign s_cyc   = cyc_q;

endmodule

// File: tb/tb_wb_bus_arb.sv
// Scoreboard bench for wb_bus_arb: directed transactions push expected responses,
// a monitor pops and compares on every m_ack/m_err.
module tb_wb_bus_arb;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 22;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wmsk;
    logic              m_we;
    logic              m_cyc;
    logic [DW-1:0]     m_rdata;
    logic              m_ack;
    logic              m_err;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wmsk;
    logic              s_we;
    logic [N-1:0]      s_cyc;
    logic [N-1:0]      s_ack;
    logic [N*DW-1:0]   s_rdata;

    wb_bus_arb #(
        .N(N), .DW(DW), .AW(AW), .SEL_LSB(18), .SEL_W(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmsk(m_wmsk), .m_we(m_we), .m_cyc(m_cyc),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmsk(s_wmsk), .s_we(s_we),
        .s_cyc(s_cyc), .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    typedef struct {
        logic          err;
        logic [31:0]   rdata;
        int            cyc_n;
        logic [3:0]    mask;
        logic [21:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wmsk;
        logic          we;
        int            start;
        int            cyc_lat;
        int            resp_lat;
        int            period;
    } exp_t;

    exp_t sb_q[$];

    // Slave model: slave i acks on the delay[i]-th cycle of its s_cyc (0 = never).
    int   delay [N];
    int   scnt  [N];
    logic spur;

    initial begin
        logic [N-1:0] nxt;
        s_ack = '0;
        for (int i = 0; i < N; i++) scnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                scnt[i] = s_cyc[i] ? scnt[i] + 1 : 0;
                nxt[i]  = s_cyc[i] && (delay[i] != 0) && (scnt[i] == delay[i]);
            end
            nxt[0] = nxt[0] | spur;
            s_ack  = nxt;
        end
    end

    // Monitor
    initial begin
        exp_t          e;
        int            acc_cnt;
        logic [N-1:0]  acc_mask;
        int            first_cyc;
        int            prev_resp;
        acc_cnt   = 0;
        acc_mask  = '0;
        first_cyc = -1;
        prev_resp = -100;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                acc_cnt   = 0;
                acc_mask  = '0;
                first_cyc = -1;
            end else begin
                if (s_cyc != '0) begin
                    if (first_cyc < 0) first_cyc = cycle;
                    acc_cnt++;
                    acc_mask |= s_cyc;
                    check("s_cyc_onehot", $onehot(s_cyc), 1);
                    if (sb_q.size() > 0) begin
                        check("s_addr",  s_addr,  sb_q[0].addr);
                        check("s_wdata", s_wdata, sb_q[0].wdata);
                        check("s_wmsk",  s_wmsk,  sb_q[0].wmsk);
                        check("s_we",    s_we,    sb_q[0].we);
                    end
                end
                if (m_ack || m_err) begin
                    check("ack_err_exclusive", m_ack & m_err, 0);
                    check("resp_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("resp_is_err",  m_err,    e.err);
                        check("m_rdata",      m_rdata,  e.rdata);
                        check("s_cyc_cycles", acc_cnt,  e.cyc_n);
                        check("s_cyc_mask",   acc_mask, e.mask);
                        if (e.cyc_lat >= 0)  check("s_cyc_latency", first_cyc - e.start, e.cyc_lat);
                        if (e.resp_lat >= 0) check("resp_latency",  cycle - e.start,     e.resp_lat);
                        if (e.period >= 0)   check("txn_period",    cycle - prev_resp,   e.period);
                    end
                    prev_resp = cycle;
                    acc_cnt   = 0;
                    acc_mask  = '0;
                    first_cyc = -1;
                end
            end
        end
    end

    task automatic do_txn(input logic [21:0] addr, input logic we, input logic [31:0] wd,
                          input logic [3:0] wm, input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_n, input logic [3:0] exp_mask,
                          input int cyc_lat, input int resp_lat, input int period);
        exp_t e;
        logic done;
        e.err = exp_err;   e.rdata = exp_rd;  e.cyc_n = exp_n;   e.mask = exp_mask;
        e.addr = addr;     e.wdata = wd;      e.wmsk = wm;       e.we = we;
        e.start = cycle;   e.cyc_lat = cyc_lat; e.resp_lat = resp_lat; e.period = period;
        sb_q.push_back(e);
        m_addr  = addr;
        m_we    = we;
        m_wdata = wd;
        m_wmsk  = wm;
        m_cyc   = 1'b1;
        done    = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (m_ack || m_err) done = 1'b1;
        end
        check("txn_completed", done, 1);
        m_cyc = 1'b0;
    endtask

    initial begin
        logic started;
        spur    = 1'b0;
        for (int i = 0; i < N; i++) delay[i] = 0;
        s_rdata = {32'h33333333, 32'h22222222, 32'h12345678, 32'hDEAD0000};
        m_addr  = '0;
        m_wdata = '0;
        m_wmsk  = '0;
        m_we    = 1'b0;
        m_cyc   = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_m_ack",   m_ack,   0);
        check("reset_m_err",   m_err,   0);
        check("reset_m_rdata", m_rdata, 0);
        check("reset_s_cyc",   s_cyc,   0);

        // Read slot 1, ack on 3rd cycle: s_cyc at +2, m_ack at +5
        delay[1] = 3;
        do_txn(22'h040010, 1'b0, 32'h0, 4'hF, 1'b0, 32'h12345678, 3, 4'b0010, 2, 5, -1);
        // Back-to-back write slot 3 then read slot 0: period 5 through GAP
        delay[3] = 1;
        do_txn(22'h0C0024, 1'b1, 32'hA5A5A5A5, 4'b0110, 1'b0, 32'h33333333, 1, 4'b1000, -1, -1, 5);
        delay[0] = 1;
        do_txn(22'h000008, 1'b0, 32'h0, 4'hF, 1'b0, 32'hDEAD0000, 1, 4'b0001, -1, -1, 5);
        // Unmapped slot 7
        do_txn(22'h1C0000, 1'b0, 32'h0, 4'hF, 1'b1, 32'hFFFFFFFF, 0, 4'b0000, -1, -1, -1);
        repeat (2) @(negedge clk);
        // Timeout: s_cyc held TO+1 = 16 cycles, ERR right after
        delay[2] = 0;
        do_txn(22'h080000, 1'b0, 32'h0, 4'hF, 1'b1, 32'hFFFFFFFF, 16, 4'b0100, 2, 18, -1);
        // Ack on the 16th cycle beats expiry
        delay[2] = 16;
        do_txn(22'h080004, 1'b0, 32'h0, 4'hF, 1'b0, 32'h22222222, 16, 4'b0100, -1, -1, -1);
        // Spurious ack from slave 0 while slot 2 is busy
        spur     = 1'b1;
        delay[2] = 2;
        do_txn(22'h08000C, 1'b0, 32'h0, 4'hF, 1'b0, 32'h22222222, 2, 4'b0100, -1, -1, -1);
        spur = 1'b0;

        // Reset during BUSY: no response expected, s_cyc drops next cycle
        delay[1] = 0;
        m_addr   = 22'h040020;
        m_we     = 1'b0;
        m_cyc    = 1'b1;
        started  = 1'b0;
        for (int k = 0; k < 10 && !started; k++) begin
            @(negedge clk);
            if (s_cyc != '0) started = 1'b1;
        end
        check("rst_txn_started", started, 1);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        m_cyc = 1'b0;
        @(negedge clk);
        check("rst_s_cyc",   s_cyc,   0);
        check("rst_m_ack",   m_ack,   0);
        check("rst_m_err",   m_err,   0);
        check("rst_m_rdata", m_rdata, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Fresh request after reset
        delay[1] = 1;
        do_txn(22'h040004, 1'b0, 32'h0, 4'hF, 1'b0, 32'h12345678, 1, 4'b0010, 2, 3, -1);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
